// File: rtl/tt_shell_pkg.sv
// Shared definitions for the multi-core TinyTapeout pin shell:
// command magic nibble, selector FSM states and selector width helper.
package tt_shell_pkg;

  // Upper nibble of a synchronised ui_in byte that marks it as a command.
  localparam logic [3:0] CMD_MAGIC = 4'hA;

  // HOLD: selected core in reset, pins quiet. RUN: selected core live.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width of the core index, never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tt_sync.sv
// Multi-stage flop chain synchroniser for asynchronous pin inputs.
// All stages clear on reset; q is the output of the last stage.
module tt_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  // Shift the pin value through the chain, first stage samples d.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/tt_core_select.sv
// Hosts N_CORES user cores behind one set of TinyTapeout pins.
// A debounced pin command selects the live core; the newly selected core
// is held in reset for RST_STRETCH cycles before its outputs reach the pins.
module tt_core_select
  import tt_shell_pkg::*;
#(
  parameter  int N_CORES     = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CMD_HOLD    = 4,
  parameter  int RST_STRETCH = 16,
  localparam int SEL_W       = sel_width(N_CORES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           ui_in,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uo_out,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic [7:0]           core_ui_in,
  output logic [7:0]           core_uio_in,
  input  logic [8*N_CORES-1:0] core_uo_out,
  input  logic [8*N_CORES-1:0] core_uio_out,
  input  logic [8*N_CORES-1:0] core_uio_oe,
  output logic [N_CORES-1:0]   core_reset,
  output logic [SEL_W-1:0]     sel
);

  localparam int CNT_W = $clog2(CMD_HOLD + 1);
  localparam int STR_W = $clog2(RST_STRETCH + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT     = CNT_W'(CMD_HOLD);
  localparam logic [STR_W-1:0] STRETCH_INIT = STR_W'(RST_STRETCH);

  // ---------------------------------------------------------------
  // Input synchronisation (both pin buses through one chain)
  // ---------------------------------------------------------------
  logic [15:0] sync_q;

  tt_sync #(
    .WIDTH  (16),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({uio_in, ui_in}),
    .q     (sync_q)
  );

  assign core_ui_in  = sync_q[7:0];
  assign core_uio_in = sync_q[15:8];

  // ---------------------------------------------------------------
  // Command debounce
  // ---------------------------------------------------------------
  logic [7:0]       cmd_byte;
  logic             is_cmd;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [7:0]       prev_reg;
  logic             armed_reg, armed_next;
  logic             fire;
  logic             cmd_valid;

  assign cmd_byte = sync_q[7:0];
  assign is_cmd   = (cmd_byte[7:4] == CMD_MAGIC);

  // Count identical command samples; fire once when the run reaches CMD_HOLD.
  // A fired command disarms until a non-command sample is seen.
  always_comb begin
    count_next = '0;
    armed_next = armed_reg;
    fire       = 1'b0;
    if (!is_cmd) begin
      armed_next = 1'b1;
    end else begin
      if (cmd_byte == prev_reg) begin
        count_next = (count_reg == HOLD_CNT) ? count_reg : count_reg + 1'b1;
      end else begin
        count_next = CNT_W'(1);
      end
      if (armed_reg && (count_next == HOLD_CNT)) begin
        fire       = 1'b1;
        armed_next = 1'b0;
      end
    end
  end

  // Out-of-range indices consume the command but change nothing.
  assign cmd_valid = fire && ({28'd0, cmd_byte[3:0]} < N_CORES);

  // Debounce state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      prev_reg  <= '0;
      armed_reg <= 1'b1;
    end else begin
      count_reg <= count_next;
      prev_reg  <= cmd_byte;
      armed_reg <= armed_next;
    end
  end

  // ---------------------------------------------------------------
  // Selection FSM
  // ---------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [STR_W-1:0] stretch_reg, stretch_next;
  logic [SEL_W-1:0] sel_reg, sel_next;

  // Next state: a valid command always restarts HOLD; HOLD counts down to RUN.
  always_comb begin
    state_next   = state_reg;
    stretch_next = stretch_reg;
    sel_next     = sel_reg;
    if (cmd_valid) begin
      sel_next     = cmd_byte[SEL_W-1:0];
      state_next   = ST_HOLD;
      stretch_next = STRETCH_INIT;
    end else if (state_reg == ST_HOLD) begin
      if (stretch_reg <= STR_W'(1)) begin
        state_next = ST_RUN;
      end else begin
        stretch_next = stretch_reg - 1'b1;
      end
    end
  end

  // FSM state registers; reset selects core 0 and starts a full stretch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_HOLD;
      stretch_reg <= STRETCH_INIT;
      sel_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      stretch_reg <= stretch_next;
      sel_reg     <= sel_next;
    end
  end

  assign sel = sel_reg;

  // ---------------------------------------------------------------
  // Per-core slices and reset vector
  // ---------------------------------------------------------------
  logic [7:0]         uo_slice  [N_CORES];
  logic [7:0]         uio_slice [N_CORES];
  logic [7:0]         oe_slice  [N_CORES];
  logic [N_CORES-1:0] core_reset_next;

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
    assign uo_slice[gi]  = core_uo_out[8*gi +: 8];
    assign uio_slice[gi] = core_uio_out[8*gi +: 8];
    assign oe_slice[gi]  = core_uio_oe[8*gi +: 8];
    // Only the selected core, and only while running, is out of reset.
    assign core_reset_next[gi] = !((state_next == ST_RUN) && (sel_next == SEL_W'(gi)));
  end

  // Core reset register, aligned with the state it reflects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      core_reset <= '1;
    end else begin
      core_reset <= core_reset_next;
    end
  end

  // ---------------------------------------------------------------
  // Registered output mux
  // ---------------------------------------------------------------
  // Pass the selected core's pins only while running and not switching, so
  // the old core's outputs are never paired with a new selection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
    end else if ((state_reg == ST_RUN) && !cmd_valid) begin
      uo_out  <= uo_slice[sel_reg];
      uio_out <= uio_slice[sel_reg];
      uio_oe  <= oe_slice[sel_reg];
    end else begin
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
    end
  end

endmodule

// File: tb/tb_tt_core_select.sv
// Self-checking bench for tt_core_select: a cycle-count based reference
// model checked every clock, directed literal checks, then random traffic.
module tb_tt_core_select;

  localparam int N = 4;
  localparam int S = 2;
  localparam int H = 4;
  localparam int R = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]     ui_in  = 8'h00;
  logic [7:0]     uio_in = 8'h00;
  logic [7:0]     uo_out, uio_out, uio_oe, core_ui_in, core_uio_in;
  logic [8*N-1:0] core_uo_out, core_uio_out, core_uio_oe;
  logic [N-1:0]   core_reset;
  logic [1:0]     sel;

  logic [7:0] c_uo  [N];
  logic [7:0] c_uio [N];
  logic [7:0] c_oe  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign core_uo_out[8*gi +: 8]  = c_uo[gi];
    assign core_uio_out[8*gi +: 8] = c_uio[gi];
    assign core_uio_oe[8*gi +: 8]  = c_oe[gi];
  end

  tt_core_select #(
    .N_CORES     (N),
    .SYNC_STAGES (S),
    .CMD_HOLD    (H),
    .RST_STRETCH (R)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ui_in        (ui_in),
    .uio_in       (uio_in),
    .uo_out       (uo_out),
    .uio_out      (uio_out),
    .uio_oe       (uio_oe),
    .core_ui_in   (core_ui_in),
    .core_uio_in  (core_uio_in),
    .core_uo_out  (core_uo_out),
    .core_uio_out (core_uio_out),
    .core_uio_oe  (core_uio_oe),
    .core_reset   (core_reset),
    .sel          (sel)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin history gives the synchronised view; selection is tracked as
  // "which core, and at which cycle it was last (re)selected".
  logic [15:0] hist[$];
  logic [15:0] samp;
  int          m_sel, m_cyc, m_fire_cyc, m_run;
  bit          m_live, m_armed, m_fire, live_before;
  int          sel_before;
  logic [7:0]  m_last, e_uo, e_uio, e_oe;
  logic [N-1:0] e_rst;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < S; i++) hist.push_front(16'h0000);
    m_sel = 0; m_cyc = 0; m_fire_cyc = 0; m_run = 0;
    m_live = 0; m_armed = 1; m_last = 8'h00;
    e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      model_reset();
    end else begin
      samp = hist[S-1];
      m_cyc++;
      if (samp[7:4] == 4'hA && samp[7:0] == m_last && m_run > 0) m_run++;
      else m_run = (samp[7:4] == 4'hA) ? 1 : 0;
      m_last = samp[7:0];
      m_fire = 0;
      if (samp[7:4] != 4'hA) m_armed = 1;
      else if (m_armed && m_run == H) begin
        m_armed = 0;
        if (int'(samp[3:0]) < N) m_fire = 1;
      end
      live_before = m_live;
      sel_before  = m_sel;
      if (live_before && !m_fire) begin
        e_uo = c_uo[sel_before]; e_uio = c_uio[sel_before]; e_oe = c_oe[sel_before];
      end else begin
        e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00;
      end
      if (m_fire) begin
        m_sel = int'(samp[3:0]);
        m_fire_cyc = m_cyc;
      end
      m_live = (m_cyc - m_fire_cyc) >= R;
      hist.push_front({uio_in, ui_in});
      void'(hist.pop_back());
    end
    e_rst = '1;
    if (m_live) e_rst[m_sel] = 1'b0;
    #1;
    chk("uo_out", {24'd0, uo_out}, {24'd0, e_uo});
    chk("uio_out", {24'd0, uio_out}, {24'd0, e_uio});
    chk("uio_oe", {24'd0, uio_oe}, {24'd0, e_oe});
    chk("core_reset", {28'd0, core_reset}, {28'd0, e_rst});
    chk("sel", {30'd0, sel}, m_sel);
    chk("core_ui_in", {24'd0, core_ui_in}, {24'd0, hist[S-1][7:0]});
    chk("core_uio_in", {24'd0, core_uio_in}, {24'd0, hist[S-1][15:8]});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    ui_in = v;
    cyc(n);
  endtask

  task automatic fixed_cores();
    c_uo[0] = 8'h5A; c_uo[1] = 8'h11; c_uo[2] = 8'hC3; c_uo[3] = 8'h3C;
    c_uio[0] = 8'h01; c_uio[1] = 8'h12; c_uio[2] = 8'h23; c_uio[3] = 8'h34;
    c_oe[0] = 8'hF0; c_oe[1] = 8'h0F; c_oe[2] = 8'hAA; c_oe[3] = 8'hFF;
  endtask

  initial begin
    int n, pulses;
    logic [N-1:0] prev_rst;
    logic [7:0] v;
    int len, r;

    fixed_cores();
    reset = 1'b1;
    cyc(3);
    chk("reset_core_reset", {28'd0, core_reset}, 32'hF);
    chk("reset_uo_out", {24'd0, uo_out}, 32'h0);
    chk("reset_sel", {30'd0, sel}, 32'h0);
    reset = 1'b0;

    // Core 0 held for 16 cycles after release, then live.
    for (int i = 1; i < R; i++) begin
      cyc(1);
      chk("release_hold", {28'd0, core_reset}, 32'hF);
    end
    cyc(1);
    chk("release_run", {28'd0, core_reset}, 32'hE);
    chk("release_uo_zero", {24'd0, uo_out}, 32'h0);
    cyc(1);
    chk("release_uo_core0", {24'd0, uo_out}, 32'h5A);

    // Select core 2: latency from pin to sel change, then stretch.
    ui_in = 8'hA2;
    n = 0;
    while (sel != 2'd2 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("cmd_latency", n, S + H);
    chk("sel2_hold_rst", {28'd0, core_reset}, 32'hF);
    chk("sel2_hold_uo", {24'd0, uo_out}, 32'h0);
    ui_in = 8'h00;
    for (int i = 1; i < R; i++) begin
      cyc(1);
      chk("sel2_hold_rst", {28'd0, core_reset}, 32'hF);
      chk("sel2_hold_oe", {24'd0, uio_oe}, 32'h0);
    end
    cyc(1);
    chk("sel2_run_rst", {28'd0, core_reset}, 32'hB);
    cyc(1);
    chk("sel2_uo", {24'd0, uo_out}, 32'hC3);

    // Too-short command: no switch, no pulse.
    drive(8'hA2, 3);
    drive(8'h00, 10);
    chk("short_sel", {30'd0, sel}, 32'h2);
    chk("short_rst", {28'd0, core_reset}, 32'hB);

    // Out-of-range index: ignored.
    drive(8'hA7, 10);
    chk("range_sel", {30'd0, sel}, 32'h2);
    chk("range_rst", {28'd0, core_reset}, 32'hB);
    drive(8'h00, 4);

    // Long hold fires exactly once.
    pulses = 0;
    prev_rst = core_reset;
    ui_in = 8'hA1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (core_reset == 4'hF && prev_rst != 4'hF) pulses++;
      prev_rst = core_reset;
    end
    chk("long_hold_pulses", pulses, 1);
    chk("long_hold_rst", {28'd0, core_reset}, 32'hD);

    // Gap then a fresh 4-cycle command re-resets core 1.
    pulses = 0;
    for (int i = 0; i < 37; i++) begin
      ui_in = (i >= 3 && i < 7) ? 8'hA1 : 8'h00;
      cyc(1);
      if (core_reset == 4'hF && prev_rst != 4'hF) pulses++;
      prev_rst = core_reset;
    end
    chk("rearm_pulses", pulses, 1);
    chk("rearm_rst", {28'd0, core_reset}, 32'hD);

    // Random traffic checked by the model.
    for (int b = 0; b < 400; b++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: begin v = 8'($urandom); len = $urandom_range(1, 6); end
        1: begin v = {4'hA, 4'($urandom_range(0, 15))}; len = $urandom_range(1, 6); end
        2: begin v = {4'hA, 4'($urandom_range(0, 3))}; len = $urandom_range(4, 24); end
        default: begin v = 8'h00; len = $urandom_range(1, 30); end
      endcase
      ui_in = v;
      for (int k = 0; k < len; k++) begin
        uio_in = 8'($urandom);
        for (int c = 0; c < N; c++) begin
          c_uo[c] = 8'($urandom); c_uio[c] = 8'($urandom); c_oe[c] = 8'($urandom);
        end
        cyc(1);
      end
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
      end
    end

    // Asynchronous reset while core 3 runs.
    fixed_cores();
    drive(8'h00, 5);
    drive(8'hA3, 6);
    ui_in = 8'h00;
    n = 0;
    while (core_reset != 4'h7 && n < 80) begin
      cyc(1);
      n++;
    end
    chk("core3_running", {28'd0, core_reset}, 32'h7);
    cyc(2);
    chk("core3_uo", {24'd0, uo_out}, 32'h3C);
    #2 reset = 1'b1;
    #1;
    chk("async_uo", {24'd0, uo_out}, 32'h0);
    chk("async_oe", {24'd0, uio_oe}, 32'h0);
    chk("async_sel", {30'd0, sel}, 32'h0);
    chk("async_rst", {28'd0, core_reset}, 32'hF);
    cyc(2);
    reset = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tt_core_select.md
# tt_core_select

Parametrised successor to the single-core pin wrapper: hosts `N_CORES` user cores behind one set of TinyTapeout pins. Only one core is live at a time. A pin-level command selects the live core, and a reset-stretch sequence brings the newly selected core up cleanly. The block provides:
- input synchronisation,
- registered, glitch-free output muxing,
- per-core reset control.

It sits between the top-level pin shell and the user cores.

## Interface
Parameters:
- `N_CORES`, default 4: number of hosted cores, range 2..16.
- `SYNC_STAGES`, default 2: flop stages on `ui_in`/`uio_in`, minimum 2.
- `CMD_HOLD`, default 4: consecutive identical synchronised command samples needed to trigger a switch, minimum 2.
- `RST_STRETCH`, default 16: cycles the selected core is held in reset after a switch or after block reset, minimum 1.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `ui_in` in 8: dedicated pin inputs.
- `uio_in` in 8: bidirectional pin input path.
- `uo_out` out 8: dedicated pin outputs, registered.
- `uio_out` out 8: bidirectional output path, registered.
- `uio_oe` out 8: bidirectional enables, registered; 1 = output.
- `core_ui_in` out 8: synchronised `ui_in`, broadcast to all cores.
- `core_uio_in` out 8: synchronised `uio_in`, broadcast to all cores.
- `core_uo_out` in 8*N_CORES: per-core outputs; core k occupies bits [8k+7:8k].
- `core_uio_out` in 8*N_CORES: per-core bidirectional outputs, same packing.
- `core_uio_oe` in 8*N_CORES: per-core enables, same packing.
- `core_reset` out N_CORES: per-core active-high reset.
- `sel` out SEL_W: index of the live core, where SEL_W = max(1, clog2(N_CORES)).

## Operation
States:
- HOLD: selected core in reset, pins quiet.
- RUN: selected core live.

Command:
- A synchronised `ui_in` sample with [7:4] = CMD_MAGIC (4'hA) is a command.
- `ui_in`[3:0] of that sample is the requested index.
- A debounce counter counts consecutive cycles in which the synchronised command byte is identical. Any differing or non-command sample clears it.
- When the count reaches `CMD_HOLD`, the command fires exactly once. It re-arms only after at least one non-command sample.
- Requested index ≥ `N_CORES`: the command is ignored, with no state change and no reset pulse.
- A valid command fires in either state: `sel` loads the index, the state goes to HOLD, and the stretch counter loads `RST_STRETCH`.
- Re-selecting the current index is legal and simply re-resets that core.

HOLD:
- `core_reset`[sel] = 1.
- `uo_out`, `uio_out` and `uio_oe` are forced to 0.
- The counter decrements each cycle. At 1, the next state is RUN.

RUN:
- `core_reset`[sel] = 0.
- `uo_out`, `uio_out` and `uio_oe` register the slices of core `sel`.

Other rules:
- Non-selected cores: `core_reset` = 1 at all times.
- `core_ui_in` and `core_uio_in` are always the synchronised inputs, including during HOLD, so a core can see its pins before release.

## Timing
Reset values (`reset` asserted, asynchronous):
- state = HOLD, `sel` = 0, stretch counter = `RST_STRETCH`, debounce = 0.
- `core_reset` = all ones.
- `uo_out`, `uio_out`, `uio_oe` = 0.
- Synchroniser flops = 0.

After reset release:
- Core 0 is held for `RST_STRETCH` cycles.
- `core_reset`[0] falls in cycle `RST_STRETCH` after the first clock edge.

Latencies:
- Pin to core: `SYNC_STAGES` cycles.
- Core output to pin in RUN: 1 cycle.
- Command stable on the pin at edge t: fires at edge t + `SYNC_STAGES` + `CMD_HOLD` − 1.
- On firing: `sel`, `core_reset` and the zeroed outputs all take effect at the next edge. No cycle mixes the old core's outputs with the new `sel`.

Reset mid-HOLD or mid-RUN: immediate return to reset values, with selection lost.

A new valid command during HOLD restarts the stretch from `RST_STRETCH`.

## Structure
- Package `tt_shell_pkg` holds:
  - `CMD_MAGIC`
  - the state enum (HOLD, RUN)
  - the `sel_width(n)` function
- Sub-module `tt_sync`: a width- and `SYNC_STAGES`-parametrised flop chain with asynchronous reset. It is instanced once for the 16-bit concatenation {`uio_in`, `ui_in`}.
- Output mux, debounce and FSM live in `tt_core_select`.

## Test plan
- Reset release with defaults:
  - `core_reset` = 4'b1111 for 16 cycles, then 4'b1110.
  - Core 0 `uo_out` = 8'h5A drive appears on `uo_out` 1 cycle after RUN.
- Hold `ui_in` = 8'hA2 for 4 synchronised cycles:
  - `sel` = 2, outputs = 0 during 16-cycle HOLD, `core_reset` = 4'b1111.
  - Then 4'b1011, and `uo_out` follows core 2 = 8'hC3.
- `ui_in` = 8'hA2 for only 3 cycles, then 8'h00: no switch, and `sel` is unchanged.
- `ui_in` = 8'hA7 with `N_CORES` = 4: ignored, no reset pulse, `sel` unchanged.
- 8'hA1 held for 40 cycles: exactly one switch. Then 8'h00 followed by 8'hA1 held 4 cycles: a second reset pulse of core 1.
- `reset` asserted mid-RUN on core 3: in the same cycle, outputs = 0, `sel` = 0 and `core_reset` = 4'b1111, asynchronously.
